// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: opcodes, funct3 codes, LSU state encodings and access-size helpers
package mem_stage_lsu_pkg;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] LSU_IDLE     = 2'd0;
  localparam logic [1:0] LSU_REQ      = 2'd1;
  localparam logic [1:0] LSU_WAIT_RSP = 2'd2;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
  // unsigned variants only exist for loads; anything unrecognised is a word access
  function automatic size_e access_size(input logic [2:0] f3, input logic load);
    return (f3 == F3_B || (load && f3 == F3_BU)) ? SZ_B :
           (f3 == F3_H || (load && f3 == F3_HU)) ? SZ_H : SZ_W;
  endfunction
  function automatic logic [3:0] store_be(input size_e sz, input logic [1:0] a);
    return sz == SZ_B ? 4'b0001 << a : sz == SZ_H ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// lsu_load_align: selects the addressed lane of a load word and sign/zero extends it
module lsu_load_align import mem_stage_lsu_pkg::*; #(
  parameter int REG_WIDTH = 32
) (
  input  logic [2:0]           funct3,
  input  logic [1:0]           offset,
  input  logic [REG_WIDTH-1:0] rdata,
  output logic [REG_WIDTH-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    data = funct3 == F3_B  ? {{(REG_WIDTH-8){b[7]}}, b} :
           funct3 == F3_BU ? {{(REG_WIDTH-8){1'b0}}, b} :
           funct3 == F3_H  ? {{(REG_WIDTH-16){h[15]}}, h} :
           funct3 == F3_HU ? {{(REG_WIDTH-16){1'b0}}, h} : rdata;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with valid/ready dmem port and pipeline stall.
// Define MISALIGN_TRAP_EN to turn misaligned accesses into error writebacks instead of requests.
module mem_stage_lsu import mem_stage_lsu_pkg::*; #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      EX_MEM_valid,
  input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]      EX_MEM_dataB,
  input  logic [6:0]                EX_MEM_inst_opcode,
  input  logic [2:0]                EX_MEM_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      EX_MEM_reg_write_en,
  output logic                      mem_stall,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic                      dmem_req_we,
  output logic [REG_WIDTH-1:0]      dmem_req_addr,
  output logic [REG_WIDTH-1:0]      dmem_req_wdata,
  output logic [3:0]                dmem_req_be,
  input  logic                      dmem_rsp_valid,
  input  logic [REG_WIDTH-1:0]      dmem_rsp_rdata,
  output logic                      wb_valid,
  output logic [REG_WIDTH-1:0]      wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      wb_reg_write_en,
  output logic                      misalign_err
);
  logic [1:0]                state;
  logic [REG_WIDTH-1:0]      addr_q, wdata_q, load_data;
  logic [3:0]                be_q;
  logic                      store_q, we_q, is_load, mem_op, mis;
  logic [2:0]                f3_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  size_e                     sz;
  assign is_load = EX_MEM_inst_opcode == OPCODE_LOAD;
  assign mem_op  = EX_MEM_valid & (is_load | EX_MEM_inst_opcode == OPCODE_STORE);
  assign sz      = access_size(EX_MEM_funct3, is_load);
`ifdef MISALIGN_TRAP_EN
  assign mis = mem_op & (((sz == SZ_H) & EX_MEM_alu_out[0]) | ((sz == SZ_W) & |EX_MEM_alu_out[1:0]));
`else
  assign mis = 1'b0;
`endif
  assign dmem_req_valid = state == LSU_REQ;
  assign dmem_req_we    = store_q;
  assign dmem_req_addr  = {addr_q[REG_WIDTH-1:2], 2'b00};
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_be    = be_q;
  // a trapped access completes like an ALU op, so it must not hold the pipeline
  assign mem_stall = reset_n & (((state == LSU_IDLE) & mem_op & ~mis) |
                                (dmem_req_valid & ~(store_q & dmem_req_ready)) |
                                ((state == LSU_WAIT_RSP) & ~dmem_rsp_valid));
  lsu_load_align #(.REG_WIDTH(REG_WIDTH)) u_align (
    .funct3(f3_q),
    .offset(addr_q[1:0]),
    .rdata (dmem_rsp_rdata),
    .data  (load_data)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= LSU_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      store_q         <= 1'b0;
      we_q            <= 1'b0;
      f3_q            <= '0;
      rd_q            <= '0;
      wb_valid        <= 1'b0;
      wb_data         <= '0;
      wb_rd           <= '0;
      wb_reg_write_en <= 1'b0;
      misalign_err    <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      if (state == LSU_IDLE && EX_MEM_valid && (!mem_op || mis)) begin
        wb_valid        <= 1'b1;
        wb_data         <= EX_MEM_alu_out;
        wb_rd           <= EX_MEM_rd;
        wb_reg_write_en <= EX_MEM_reg_write_en & ~mem_op;
        misalign_err    <= mis;
      end else if (state == LSU_IDLE && mem_op) begin
        state   <= LSU_REQ;
        addr_q  <= EX_MEM_alu_out;
        store_q <= ~is_load;
        f3_q    <= EX_MEM_funct3;
        rd_q    <= EX_MEM_rd;
        we_q    <= EX_MEM_reg_write_en;
        wdata_q <= sz == SZ_B ? {(REG_WIDTH/8){EX_MEM_dataB[7:0]}} :
                   sz == SZ_H ? {(REG_WIDTH/16){EX_MEM_dataB[15:0]}} : EX_MEM_dataB;
        be_q    <= is_load ? 4'b1111 : store_be(sz, EX_MEM_alu_out[1:0]);
      end else if (dmem_req_valid && dmem_req_ready) begin
        state <= store_q ? LSU_IDLE : LSU_WAIT_RSP;
        if (store_q) begin
          wb_valid        <= 1'b1;
          wb_data         <= addr_q;
          wb_rd           <= rd_q;
          wb_reg_write_en <= 1'b0;
        end
      end else if (state == LSU_WAIT_RSP && dmem_rsp_valid) begin
        state           <= LSU_IDLE;
        wb_valid        <= 1'b1;
        wb_data         <= load_data;
        wb_rd           <= rd_q;
        wb_reg_write_en <= we_q;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized checks of mem_stage_lsu against an arithmetic reference model.
// Expectations follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_stage_lsu;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ALU = 7'b0110011, ALUI = 7'b0010011;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, reset_n;
  logic EX_MEM_valid, EX_MEM_reg_write_en;
  logic [31:0] EX_MEM_alu_out, EX_MEM_dataB;
  logic [6:0] EX_MEM_inst_opcode;
  logic [2:0] EX_MEM_funct3;
  logic [4:0] EX_MEM_rd;
  logic mem_stall, dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_rsp_valid;
  logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata, wb_data;
  logic [3:0] dmem_req_be;
  logic wb_valid, wb_reg_write_en, misalign_err;
  logic [4:0] wb_rd;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .reset_n(reset_n),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_dataB(EX_MEM_dataB),
    .EX_MEM_inst_opcode(EX_MEM_inst_opcode), .EX_MEM_funct3(EX_MEM_funct3), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_reg_write_en(EX_MEM_reg_write_en), .mem_stall(mem_stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write_en(wb_reg_write_en),
    .misalign_err(misalign_err)
  );

  typedef struct packed {
    logic        seen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        unstable;
    int          stall_cycles;
    int          lat;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        mis;
    logic        timeout;
  } res_t;

  function automatic int nbytes(input logic [2:0] f3, input logic load);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd4: return load ? 1 : 4;
      3'd5: return load ? 2 : 4;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic load, input logic [31:0] a);
    int nb = nbytes(f3, load);
    if (load) return 4'hF;
    return 4'((nb == 1) ? (1 << (a % 4)) : (nb == 2) ? (3 << ((a % 4) & 2)) : 15);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int nb = nbytes(f3, 1'b0);
    return nb == 1 ? (d & 32'hFF) * 32'h01010101 : nb == 2 ? (d & 32'hFFFF) * 32'h00010001 : d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    int nb = nbytes(f3, 1'b1);
    int off = nb == 1 ? int'(a % 4) : nb == 2 ? int'((a % 4) & 2) : 0;
    longint v = longint'((rdata >> (8 * off))) & ((64'd1 << (8 * nb)) - 1);
    if (nb < 4 && !f3[2] && v >= longint'(64'd1 << (8 * nb - 1))) v = v - longint'(64'd1 << (8 * nb));
    return 32'(v);
  endfunction

  function automatic logic misal(input logic [2:0] f3, input logic load, input logic [31:0] a);
    int nb = nbytes(f3, load);
    return (nb == 2 && a[0]) || (nb == 4 && (a % 4) != 0);
  endfunction

  // drives one instruction, plays the memory side with the given delays, and reports what it saw
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic we, input int rdy, input int rsp,
                       input logic [31:0] rdata, output res_t r);
    int rc = 0, wc = -1;
    logic consumed = 1'b0, acc, rsp_now, done = 1'b0;
    r = '0;
    r.lat = -1;
    @(negedge clk);
    EX_MEM_valid = 1'b1; EX_MEM_inst_opcode = op; EX_MEM_funct3 = f3; EX_MEM_alu_out = a;
    EX_MEM_dataB = d; EX_MEM_rd = rd; EX_MEM_reg_write_en = we; dmem_rsp_rdata = rdata;
    for (int cyc = 0; cyc < 60; cyc++) begin
      dmem_req_ready = dmem_req_valid && (rc >= rdy);
      if (dmem_req_valid) rc++;
      dmem_rsp_valid = (wc == rsp);
      #1;
      if (dmem_req_valid) begin
        if (!r.seen) begin
          r.seen = 1'b1; r.addr = dmem_req_addr; r.wdata = dmem_req_wdata; r.be = dmem_req_be; r.we = dmem_req_we;
        end else if ({r.addr, r.wdata, r.be, r.we} !== {dmem_req_addr, dmem_req_wdata, dmem_req_be, dmem_req_we})
          r.unstable = 1'b1;
      end
      if (!consumed) begin
        if (mem_stall) r.stall_cycles++;
        else consumed = 1'b1;
      end
      if (wb_valid) begin
        r.lat = cyc; r.wb_data = wb_data; r.wb_rd = wb_rd; r.wb_we = wb_reg_write_en; r.mis = misalign_err;
        done = 1'b1;
        break;
      end
      acc = dmem_req_valid && dmem_req_ready && op == LD;
      rsp_now = dmem_rsp_valid;
      @(negedge clk);
      if (consumed) EX_MEM_valid = 1'b0;
      if (rsp_now) wc = -1;
      else if (wc >= 0) wc++;
      if (acc) wc = 0;
    end
    r.timeout = !done;
    EX_MEM_valid = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if ({dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be, wb_valid, wb_data, wb_rd,
         wb_reg_write_en, misalign_err, mem_stall} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req_v=%b addr=%h be=%h wb_v=%b wb_data=%h stall=%b exp all zero",
               dmem_req_valid, dmem_req_addr, dmem_req_be, wb_valid, wb_data, mem_stall);
    end
    checks++;
    reset_n = 1'b1;
  endtask

  task automatic test_alu_pass();
    res_t r;
    do_op(ALU, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0, r);
    if (r.lat !== 1) begin failures++; $display("FAIL alu_latency got=%0d exp=1", r.lat); end
    checks++;
    if ({r.wb_data, r.wb_rd, r.wb_we} !== {32'h1234, 5'd5, 1'b1}) begin
      failures++; $display("FAIL alu_wb got data=%h rd=%0d we=%b exp data=00001234 rd=5 we=1", r.wb_data, r.wb_rd, r.wb_we);
    end
    checks++;
    if (r.stall_cycles !== 0 || r.seen !== 1'b0) begin
      failures++; $display("FAIL alu_nostall got stall_cycles=%0d req=%b exp 0 0", r.stall_cycles, r.seen);
    end
    checks++;
    @(negedge clk); #1;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL alu_pulse got wb_valid=%b exp=0", wb_valid); end
    checks++;
  endtask

  task automatic test_store_byte();
    res_t r;
    do_op(ST, 3'd0, 32'h103, 32'hAB, 5'd0, 1'b0, 0, 0, 32'h0, r);
    if ({r.seen, r.we, r.addr, r.be, r.wdata} !== {1'b1, 1'b1, 32'h100, 4'b1000, 32'hABABABAB}) begin
      failures++;
      $display("FAIL sb_req got seen=%b we=%b addr=%h be=%b wdata=%h exp 1 1 00000100 1000 abababab",
               r.seen, r.we, r.addr, r.be, r.wdata);
    end
    checks++;
    if (r.lat !== 2 || r.wb_we !== 1'b0) begin
      failures++; $display("FAIL sb_wb got lat=%0d we=%b exp lat=2 we=0", r.lat, r.wb_we);
    end
    checks++;
  endtask

  task automatic test_load_stall();
    res_t r;
    do_op(LD, 3'd0, 32'h101, 32'h0, 5'd7, 1'b1, 3, 2, 32'h000080FF, r);
    if (r.unstable !== 1'b0 || r.addr !== 32'h100 || r.be !== 4'hF || r.we !== 1'b0) begin
      failures++; $display("FAIL lb_req got unstable=%b addr=%h be=%h we=%b exp 0 00000100 f 0", r.unstable, r.addr, r.be, r.we);
    end
    checks++;
    if (r.lat !== 8 || r.stall_cycles !== 7) begin
      failures++; $display("FAIL lb_stall got lat=%0d stall_cycles=%0d exp 8 7", r.lat, r.stall_cycles);
    end
    checks++;
    if ({r.wb_data, r.wb_rd, r.wb_we} !== {32'hFFFFFF80, 5'd7, 1'b1}) begin
      failures++; $display("FAIL lb_wb got data=%h rd=%0d we=%b exp ffffff80 7 1", r.wb_data, r.wb_rd, r.wb_we);
    end
    checks++;
  endtask

  task automatic test_lhu();
    res_t r;
    do_op(LD, 3'd5, 32'h202, 32'h0, 5'd9, 1'b1, 0, 0, 32'h80010000, r);
    if (r.wb_data !== 32'h00008001 || r.lat !== 3) begin
      failures++; $display("FAIL lhu got data=%h lat=%0d exp 00008001 3", r.wb_data, r.lat);
    end
    checks++;
  endtask

  task automatic test_misalign();
    res_t r;
    do_op(LD, 3'd2, 32'h101, 32'h0, 5'd3, 1'b1, 0, 0, 32'hCAFEF00D, r);
`ifdef MISALIGN_TRAP_EN
    if ({r.seen, r.mis, r.wb_we, r.wb_data, r.lat} !== {1'b0, 1'b1, 1'b0, 32'h101, 32'd1}) begin
      failures++; $display("FAIL lw_trap got req=%b err=%b we=%b data=%h lat=%0d exp 0 1 0 00000101 1",
                           r.seen, r.mis, r.wb_we, r.wb_data, r.lat);
    end
`else
    if ({r.seen, r.addr, r.mis, r.wb_data, r.lat} !== {1'b1, 32'h100, 1'b0, 32'hCAFEF00D, 32'd3}) begin
      failures++; $display("FAIL lw_noalign got req=%b addr=%h err=%b data=%h lat=%0d exp 1 00000100 0 cafef00d 3",
                           r.seen, r.addr, r.mis, r.wb_data, r.lat);
    end
`endif
    checks++;
  endtask

  task automatic test_stray_rsp();
    @(negedge clk);
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
        failures++; $display("FAIL stray_rsp cyc%0d got wb_valid=%b stall=%b exp 0 0", i, wb_valid, mem_stall);
      end
      checks++;
    end
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    EX_MEM_valid = 1'b1; EX_MEM_inst_opcode = LD; EX_MEM_funct3 = 3'd2; EX_MEM_alu_out = 32'h300;
    EX_MEM_rd = 5'd4; EX_MEM_reg_write_en = 1'b1; dmem_req_ready = 1'b1;
    @(negedge clk); #1;
    if (dmem_req_valid !== 1'b1) begin failures++; $display("FAIL rstmid_req got=%b exp=1", dmem_req_valid); end
    checks++;
    @(negedge clk);
    EX_MEM_valid = 1'b0; dmem_req_ready = 1'b0; reset_n = 1'b0;
    @(negedge clk); #1;
    if ({dmem_req_valid, wb_valid, wb_data, dmem_req_addr, mem_stall} !== '0) begin
      failures++; $display("FAIL rstmid_outputs got req_v=%b wb_v=%b wb_data=%h addr=%h stall=%b exp all zero",
                           dmem_req_valid, wb_valid, wb_data, dmem_req_addr, mem_stall);
    end
    checks++;
    reset_n = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h12345678;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    #1;
    if ({wb_valid, dmem_req_valid, mem_stall} !== 3'b000) begin
      failures++; $display("FAIL rstmid_rsp_ignored got wb_v=%b req_v=%b stall=%b exp 000", wb_valid, dmem_req_valid, mem_stall);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev = 32'h0;
    logic [4:0] prd = 5'd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      EX_MEM_valid = i < 6; EX_MEM_inst_opcode = ALUI; EX_MEM_alu_out = $urandom; EX_MEM_rd = 5'($urandom);
      EX_MEM_reg_write_en = 1'b1;
      #1;
      if (i > 0 && (wb_valid !== 1'b1 || wb_data !== prev || wb_rd !== prd)) begin
        failures++; $display("FAIL b2b%0d got v=%b data=%h rd=%0d exp 1 %h %0d", i, wb_valid, wb_data, wb_rd, prev, prd);
      end
      if (i > 0) checks++;
      prev = EX_MEM_alu_out; prd = EX_MEM_rd;
    end
    @(negedge clk); #1;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got wb_valid=%b exp=0", wb_valid); end
    checks++;
  endtask

  task automatic test_random();
    res_t r;
    logic [6:0] ops [4] = '{LD, ST, ALU, ALUI};
    for (int i = 0; i < 60; i++) begin
      logic [6:0] op = ops[$urandom_range(0, 3)];
      logic [2:0] f3 = 3'($urandom);
      logic [31:0] a = $urandom, d = $urandom, rdata = $urandom;
      logic [4:0] rd = 5'($urandom);
      logic we = 1'($urandom);
      int rdy = $urandom_range(0, 3), rsp = $urandom_range(0, 3), el;
      logic ismem = op == LD || op == ST, load = op == LD;
      logic trap = TRAP && ismem && misal(f3, load, a);
      el = (!ismem || trap) ? 1 : load ? 3 + rdy + rsp : 2 + rdy;
      do_op(op, f3, a, d, rd, we, rdy, rsp, rdata, r);
      if (r.timeout || r.lat !== el || r.stall_cycles !== el - 1) begin
        failures++; $display("FAIL rnd%0d_timing op=%h f3=%0d got to=%b lat=%0d stall=%0d exp lat=%0d stall=%0d",
                             i, op, f3, r.timeout, r.lat, r.stall_cycles, el, el - 1);
      end
      checks++;
      if (r.seen !== (ismem && !trap) || r.mis !== trap) begin
        failures++; $display("FAIL rnd%0d_issue got req=%b err=%b exp req=%b err=%b", i, r.seen, r.mis, ismem && !trap, trap);
      end
      checks++;
      if (ismem && !trap) begin
        if (r.addr !== (a & ~32'd3) || r.be !== exp_be(f3, load, a) || r.we !== !load || r.unstable !== 1'b0 ||
            (!load && r.wdata !== exp_wdata(f3, d))) begin
          failures++; $display("FAIL rnd%0d_req f3=%0d a=%h got addr=%h be=%b we=%b wdata=%h unstable=%b exp addr=%h be=%b we=%b wdata=%h",
                               i, f3, a, r.addr, r.be, r.we, r.wdata, r.unstable, a & ~32'd3, exp_be(f3, load, a), !load, exp_wdata(f3, d));
        end
        checks++;
      end
      if (!ismem || trap || load) begin
        logic [31:0] ed = !ismem ? d ^ d ^ a : trap ? a : exp_load(f3, a, rdata);
        logic ewe = (!ismem || (load && !trap)) ? we : 1'b0;
        if (r.wb_data !== ed || r.wb_we !== ewe || (!trap && r.wb_rd !== rd)) begin
          failures++; $display("FAIL rnd%0d_wb op=%h f3=%0d a=%h rdata=%h got data=%h we=%b rd=%0d exp data=%h we=%b rd=%0d",
                               i, op, f3, a, rdata, r.wb_data, r.wb_we, r.wb_rd, ed, ewe, rd);
        end
      end else if (r.wb_we !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_store_we got=%b exp=0", i, r.wb_we);
      end
      checks++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    EX_MEM_valid = 1'b0; EX_MEM_alu_out = '0; EX_MEM_dataB = '0; EX_MEM_inst_opcode = '0; EX_MEM_funct3 = '0;
    EX_MEM_rd = '0; EX_MEM_reg_write_en = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    test_reset();
    test_alu_pass();
    test_store_byte();
    test_load_stall();
    test_lhu();
    test_misalign();
    test_stray_rsp();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
